column_single_sink_l1_return: RTL and testbench

Return-path counterpart of the column-wise 1st-level CNU→VNU router. It accepts VNU outgoing messages for one base-matrix column, one beat at a time, across all stride groups. For each stride group it applies the inverse circular shift, undoing the forward L1 route's shift for the same submatrix, so the messages arrive at the CNU side in check-row order. It is a 2-stage valid/ready pipeline with per-beat shift-factor tagging, layer-boundary tracking and sticky error reporting.

---
 rtl/column_single_sink_l1_return.sv | 155 +++++++++++++++
 tb/tb_column_single_sink_l1_return.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_single_sink_l1_return.sv
// Return-path L1 router for one base-matrix column: undoes the forward circular
// shift of each stride group in a two-stage valid/ready pipeline with column tagging.
module column_single_sink_l1_return #(
  parameter int QUAN_SIZE             = 3,
  parameter int STRIDE_UNIT_SIZE      = 51,
  parameter int STRIDE_WIDTH          = 5,
  parameter int BITWIDTH_SHIFT_FACTOR = $clog2(STRIDE_UNIT_SIZE-1),
  parameter int COL_CNT_WIDTH         = 5
) (
  input  logic                                                  sys_clk,
  input  logic                                                  rst,
  input  logic                                                  in_valid_i,
  output logic                                                  in_ready_o,
  input  logic [STRIDE_WIDTH*QUAN_SIZE*STRIDE_UNIT_SIZE-1:0]    in_msg_i,
  input  logic [STRIDE_WIDTH*BITWIDTH_SHIFT_FACTOR-1:0]         in_shift_i,
  input  logic                                                  in_last_i,
  output logic                                                  out_valid_o,
  input  logic                                                  out_ready_i,
  output logic [STRIDE_WIDTH*QUAN_SIZE*STRIDE_UNIT_SIZE-1:0]    out_msg_o,
  output logic                                                  out_last_o,
  output logic [COL_CNT_WIDTH-1:0]                              out_col_o,
  output logic                                                  err_o
);

  localparam int Z     = STRIDE_UNIT_SIZE;
  localparam int BSF   = BITWIDTH_SHIFT_FACTOR;
  localparam int MSG_W = STRIDE_WIDTH*QUAN_SIZE*Z;
  localparam int SH_W  = STRIDE_WIDTH*BSF;
  localparam logic [BSF-1:0]           Z_S     = BSF'(Z);
  localparam logic [COL_CNT_WIDTH-1:0] COL_MAX = '1;

  // Inverse rotate amount; factors >= Z are folded back once before inverting.
  function automatic logic [BSF-1:0] inv_amount(input logic [BSF-1:0] s);
    logic [BSF-1:0] s_red;
    s_red = (s >= Z_S) ? s - Z_S : s;
    return (s == '0) ? '0 : Z_S - s_red;
  endfunction

  // out[j] = plane[(j + r) mod Z]; r may equal Z (from s == Z), handled by one fold.
  function automatic logic [Z-1:0] rotate_plane(input logic [Z-1:0] plane,
                                                input logic [BSF-1:0] r);
    logic [Z-1:0] res;
    logic [BSF:0] idx;
    res = '0;
    for (int j = 0; j < Z; j++) begin
      idx = {1'b0, BSF'(j)} + {1'b0, r};
      if (idx >= {1'b0, Z_S}) idx = idx - {1'b0, Z_S};
      res[j] = plane[idx[BSF-1:0]];
    end
    return res;
  endfunction

  logic                     vld_p1;
  logic [MSG_W-1:0]         msg_p1;
  logic [SH_W-1:0]          rot_p1;
  logic                     last_p1;
  logic [COL_CNT_WIDTH-1:0] col_p1;

  logic                     vld_p2;
  logic [MSG_W-1:0]         msg_p2;
  logic                     last_p2;
  logic [COL_CNT_WIDTH-1:0] col_p2;

  logic [COL_CNT_WIDTH-1:0] col_cnt;
  logic [COL_CNT_WIDTH-1:0] col_nxt;
  logic                     col_wrap;
  logic                     err_q;

  logic                     adv_p2;
  logic                     in_hs;
  logic [SH_W-1:0]          rot_in;
  logic                     oor_in;
  logic [MSG_W-1:0]         rot_msg;

  assign adv_p2     = !vld_p2 || out_ready_i;
  assign in_ready_o = !vld_p1 || adv_p2;
  assign in_hs      = in_valid_i && in_ready_o;

  always_comb begin
    rot_in = '0;
    oor_in = 1'b0;
    for (int g = 0; g < STRIDE_WIDTH; g++) begin
      rot_in[g*BSF +: BSF] = inv_amount(in_shift_i[g*BSF +: BSF]);
      if (in_shift_i[g*BSF +: BSF] >= Z_S) oor_in = 1'b1;
    end
  end

  always_comb begin
    col_wrap = 1'b0;
    if (in_last_i) begin
      col_nxt = '0;
    end else if (col_cnt == COL_MAX) begin
      col_nxt  = '0;
      col_wrap = 1'b1;
    end else begin
      col_nxt = col_cnt + COL_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    rot_msg = '0;
    for (int g = 0; g < STRIDE_WIDTH; g++) begin
      for (int b = 0; b < QUAN_SIZE; b++) begin
        rot_msg[(g*QUAN_SIZE+b)*Z +: Z] =
          rotate_plane(msg_p1[(g*QUAN_SIZE+b)*Z +: Z], rot_p1[g*BSF +: BSF]);
      end
    end
  end

  // Stage 1: capture the beat, its inverse rotate amounts and its column tag
  always_ff @(posedge sys_clk) begin
    if (in_hs) begin
      msg_p1  <= in_msg_i;
      rot_p1  <= rot_in;
      last_p1 <= in_last_i;
      col_p1  <= col_cnt;
    end
  end

  // Control state plus the stage 2 output register, which must read zero after reset
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      msg_p2  <= '0;
      last_p2 <= 1'b0;
      col_p2  <= '0;
      col_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (in_hs)       vld_p1 <= 1'b1;
      else if (adv_p2) vld_p1 <= 1'b0;

      if (adv_p2) vld_p2 <= vld_p1;

      if (adv_p2 && vld_p1) begin
        msg_p2  <= rot_msg;
        last_p2 <= last_p1;
        col_p2  <= col_p1;
      end

      if (in_hs) begin
        col_cnt <= col_nxt;
        if (oor_in || col_wrap) err_q <= 1'b1;
      end
    end
  end

  assign out_valid_o = vld_p2;
  assign out_msg_o   = msg_p2;
  assign out_last_o  = last_p2;
  assign out_col_o   = col_p2;
  assign err_o       = err_q;

endmodule

// File: tb/tb_column_single_sink_l1_return.sv
// Bench for column_single_sink_l1_return: directed and random beats scored against
// a modulo-arithmetic model of the inverse shift, column tagging and error flag.
module tb_column_single_sink_l1_return;

  localparam int Q     = 3;
  localparam int Z     = 51;
  localparam int SW    = 5;
  localparam int BSF   = 6;
  localparam int CW    = 5;
  localparam int MSG_W = SW*Q*Z;
  localparam int SH_W  = SW*BSF;

  logic              sys_clk = 1'b0;
  logic              rst;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [MSG_W-1:0]  in_msg_i;
  logic [SH_W-1:0]   in_shift_i;
  logic              in_last_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [MSG_W-1:0]  out_msg_o;
  logic              out_last_o;
  logic [CW-1:0]     out_col_o;
  logic              err_o;

  always #5 sys_clk = ~sys_clk;

  column_single_sink_l1_return #(
    .QUAN_SIZE(Q), .STRIDE_UNIT_SIZE(Z), .STRIDE_WIDTH(SW),
    .BITWIDTH_SHIFT_FACTOR(BSF), .COL_CNT_WIDTH(CW)
  ) dut (
    .sys_clk(sys_clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_msg_i(in_msg_i), .in_shift_i(in_shift_i), .in_last_i(in_last_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_msg_o(out_msg_o), .out_last_o(out_last_o), .out_col_o(out_col_o),
    .err_o(err_o)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [MSG_W-1:0] q_msg[$];
  logic             q_last[$];
  logic [CW-1:0]    q_col[$];
  int               col_m;
  bit               err_m;
  bit               bp_mode;
  int               cyc;
  bit               last_in_hs;
  bit               stalled;
  logic [MSG_W-1:0] held;
  logic [MSG_W-1:0] exp_msg;

  task automatic chk(input string tag, input logic [MSG_W-1:0] obs, input logic [MSG_W-1:0] exp);
    int k;
    int p;
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      k = 0;
      for (int i = MSG_W-1; i >= 0; i--) if (obs[i] !== exp[i]) k = i;
      p = k / Z;
      $error("FAIL %s first bad bit %0d: observed plane %0h, expected plane %0h",
             tag, k, obs[p*Z +: Z], exp[p*Z +: Z]);
    end
  endtask

  // Reference: out[j] = in[(j - s) mod Z], with s >= Z reduced by Z once.
  function automatic logic [MSG_W-1:0] model(input logic [MSG_W-1:0] m, input logic [SH_W-1:0] sh);
    logic [MSG_W-1:0] o;
    int s;
    o = '0;
    for (int g = 0; g < SW; g++) begin
      s = int'(sh[g*BSF +: BSF]);
      if (s >= Z) s = s - Z;
      for (int b = 0; b < Q; b++)
        for (int j = 0; j < Z; j++)
          o[(g*Q+b)*Z + j] = m[(g*Q+b)*Z + ((j - s + Z) % Z)];
    end
    return o;
  endfunction

  // Forward L1 route: fwd[j] = in[(j + s) mod Z].
  function automatic logic [MSG_W-1:0] forward(input logic [MSG_W-1:0] m, input logic [SH_W-1:0] sh);
    logic [MSG_W-1:0] o;
    int s;
    o = '0;
    for (int g = 0; g < SW; g++) begin
      s = int'(sh[g*BSF +: BSF]);
      for (int b = 0; b < Q; b++)
        for (int j = 0; j < Z; j++)
          o[(g*Q+b)*Z + j] = m[(g*Q+b)*Z + ((j + s) % Z)];
    end
    return o;
  endfunction

  function automatic logic [MSG_W-1:0] rand_msg();
    logic [MSG_W-1:0] m;
    for (int i = 0; i < MSG_W; i++) m[i] = 1'($urandom_range(0, 1));
    return m;
  endfunction

  function automatic logic [SH_W-1:0] rand_shift();
    logic [SH_W-1:0] sh;
    for (int g = 0; g < SW; g++) sh[g*BSF +: BSF] = BSF'($urandom_range(0, Z-1));
    return sh;
  endfunction

  function automatic logic [MSG_W-1:0] lane_msg(input int lane);
    logic [MSG_W-1:0] m;
    m = '0;
    for (int p = 0; p < SW*Q; p++) m[p*Z + lane] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    int s;
    if (bp_mode) out_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    @(negedge sys_clk);
    if (stalled) begin
      chk("stall_valid", MSG_W'(out_valid_o), MSG_W'(1));
      chk("stall_msg", out_msg_o, held);
    end
    if (out_valid_o && out_ready_i) begin
      if (q_msg.size() == 0) begin
        chk("spurious_out", MSG_W'(out_valid_o), MSG_W'(0));
      end else begin
        chk("out_msg", out_msg_o, q_msg.pop_front());
        chk("out_last", MSG_W'(out_last_o), MSG_W'(q_last.pop_front()));
        chk("out_col", MSG_W'(out_col_o), MSG_W'(q_col.pop_front()));
      end
    end
    last_in_hs = in_valid_i && in_ready_o;
    if (last_in_hs) begin
      q_msg.push_back(exp_msg);
      q_last.push_back(in_last_i);
      q_col.push_back(CW'(col_m));
      for (int g = 0; g < SW; g++) begin
        s = int'(in_shift_i[g*BSF +: BSF]);
        if (s >= Z) err_m = 1'b1;
      end
      if (in_last_i) col_m = 0;
      else if (col_m == (1 << CW) - 1) begin col_m = 0; err_m = 1'b1; end
      else col_m = col_m + 1;
    end
    stalled = out_valid_o && !out_ready_i;
    held = out_msg_o;
    @(posedge sys_clk);
    #1;
    cyc++;
    chk("err_o", MSG_W'(err_o), MSG_W'(err_m));
  endtask

  task automatic send(input logic [MSG_W-1:0] m, input logic [SH_W-1:0] sh,
                      input logic last, input logic [MSG_W-1:0] e);
    in_valid_i = 1'b1;
    in_msg_i   = m;
    in_shift_i = sh;
    in_last_i  = last;
    exp_msg    = e;
    last_in_hs = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (last_in_hs) break;
    end
    if (!last_in_hs) chk("accept_timeout", MSG_W'(in_ready_o), MSG_W'(1));
  endtask

  task automatic send_rand(input logic [SH_W-1:0] sh, input logic last);
    logic [MSG_W-1:0] m;
    m = rand_msg();
    send(m, sh, last, model(m, sh));
  endtask

  task automatic drain();
    in_valid_i  = 1'b0;
    bp_mode     = 1'b0;
    out_ready_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (q_msg.size() == 0 && !out_valid_o) break;
      tick();
    end
    chk("drain_valid", MSG_W'(out_valid_o), MSG_W'(0));
    chk("drain_lost", MSG_W'(q_msg.size()), MSG_W'(0));
  endtask

  task automatic do_reset();
    in_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    q_msg.delete(); q_last.delete(); q_col.delete();
    col_m = 0; err_m = 1'b0; stalled = 1'b0;
    chk("rst_valid", MSG_W'(out_valid_o), MSG_W'(0));
    chk("rst_col", MSG_W'(out_col_o), MSG_W'(0));
    chk("rst_last", MSG_W'(out_last_o), MSG_W'(0));
    chk("rst_err", MSG_W'(err_o), MSG_W'(0));
    chk("rst_msg", out_msg_o, MSG_W'(0));
    chk("rst_ready", MSG_W'(in_ready_o), MSG_W'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MSG_W-1:0] m;
    logic [MSG_W-1:0] fwd;
    logic [SH_W-1:0]  sh;
    logic [SH_W-1:0]  sh1;

    rst = 1'b1; in_valid_i = 1'b0; in_msg_i = '0; in_shift_i = '0; in_last_i = 1'b0;
    out_ready_i = 1'b1; bp_mode = 1'b0; cyc = 0; stalled = 1'b0; exp_msg = '0;
    col_m = 0; err_m = 1'b0;
    repeat (2) @(posedge sys_clk);
    do_reset();

    // latency and identity: two register stages from acceptance to out_valid_o
    m = rand_msg();
    in_valid_i = 1'b1; in_msg_i = m; in_shift_i = '0; in_last_i = 1'b0; exp_msg = m;
    tick();
    in_valid_i = 1'b0;
    chk("lat_stage1", MSG_W'(out_valid_o), MSG_W'(0));
    tick();
    chk("lat_stage2", MSG_W'(out_valid_o), MSG_W'(1));
    drain();

    // edge rotates with directed expectations
    send(lane_msg(0), {SW{6'd1}}, 1'b0, lane_msg(1));
    send(lane_msg(0), {SW{6'd50}}, 1'b0, lane_msg(50));
    m = rand_msg();
    send(m, '0, 1'b1, m);
    drain();

    // round trip through the forward route for every shift value
    for (int s = 0; s < Z; s++) begin
      for (int g = 0; g < SW; g++) sh[g*BSF +: BSF] = BSF'((s + g) % Z);
      m   = rand_msg();
      fwd = forward(m, sh);
      send(fwd, sh, (s % 16) == 15, m);
    end
    drain();

    // random beats, random layer ends
    for (int k = 0; k < 20; k++) send_rand(rand_shift(), $urandom_range(0, 3) == 0);
    drain();

    // backpressure with ready pattern 1,0,0,1
    bp_mode = 1'b1; cyc = 0;
    for (int k = 0; k < 6; k++) send_rand(rand_shift(), 1'b0);
    drain();

    // layer tagging: last on the fourth beat
    do_reset();
    for (int k = 0; k < 5; k++) send_rand(rand_shift(), k == 3);
    drain();

    // last arriving exactly at the wrap point raises no error
    do_reset();
    for (int k = 0; k < 32; k++) send_rand(rand_shift(), k == 31);
    drain();

    // counter wrap without last raises the error
    for (int k = 0; k < 33; k++) send_rand(rand_shift(), 1'b0);
    drain();

    // out-of-range factor on group 2 behaves as s = 1 and latches err_o
    do_reset();
    sh = '0; sh[2*BSF +: BSF] = 6'd52;
    sh1 = '0; sh1[2*BSF +: BSF] = 6'd1;
    m = rand_msg();
    send(m, sh, 1'b0, model(m, sh1));
    for (int k = 0; k < 4; k++) send_rand(rand_shift(), 1'b0);
    drain();
    chk("err_sticky", MSG_W'(err_o), MSG_W'(1));
    do_reset();

    // fill both stages under stall, then reset mid-stream
    out_ready_i = 1'b0;
    send_rand(rand_shift(), 1'b0);
    send_rand(rand_shift(), 1'b0);
    in_valid_i = 1'b1;
    @(negedge sys_clk);
    chk("full_ready", MSG_W'(in_ready_o), MSG_W'(0));
    @(posedge sys_clk);
    #1;
    do_reset();
    out_ready_i = 1'b1;
    send_rand(rand_shift(), 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
